// File: rtl/abs_pkg.sv
// Shared types for the multi-wheel ABS controller: channel state encoding,
// valve levels, steering direction codes and the state-to-valve decode.
package abs_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'b00,
        ST_HOLD    = 2'b01,
        ST_RELEASE = 2'b10,
        ST_REAPPLY = 2'b11
    } abs_state_t;

    localparam logic VALVE_OPEN   = 1'b1;
    localparam logic VALVE_CLOSED = 1'b0;

    localparam logic [1:0] DIR_STRAIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT     = 2'b01;
    localparam logic [1:0] DIR_RIGHT    = 2'b10;

    typedef struct packed {
        logic vrc1;
        logic vrc2;
        logic active;
    } ch_out_t;

    function automatic ch_out_t st_outs(input abs_state_t s);
        ch_out_t o;
        o.vrc1   = (s == ST_NORMAL || s == ST_REAPPLY) ? VALVE_OPEN : VALVE_CLOSED;
        o.vrc2   = (s == ST_RELEASE) ? VALVE_OPEN : VALVE_CLOSED;
        o.active = (s != ST_NORMAL);
        return o;
    endfunction

endpackage

// File: rtl/abs_wheel_channel.sv
// One wheel of the ABS controller: divider-free slip compare, flag register,
// timed NORMAL/HOLD/RELEASE/REAPPLY FSM and saturating ABS cycle counter.
module abs_wheel_channel
    import abs_pkg::*;
#(
    parameter int SPEED_W        = 8,
    parameter int SLIP_ENTER_PCT = 20,
    parameter int SLIP_EXIT_PCT  = 10,
    parameter int STEER_COMP_PCT = 5,
    parameter int HOLD_CYCLES    = 4,
    parameter int RELEASE_MAX    = 32,
    parameter int REAPPLY_CYCLES = 8,
    parameter int MAX_ABS_CYCLES = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SPEED_W-1:0] i_wheel,
    input  logic [SPEED_W-1:0] i_vehicle,
    input  logic               i_inner,
    input  logic               i_armed,
    input  logic               i_brake,
    input  logic               i_fault,
    output logic               o_vrc1,
    output logic               o_vrc2,
    output logic               o_active,
    output logic               o_cyc_max
);

    localparam int PW   = SPEED_W + 7;
    localparam int TMAX = (RELEASE_MAX > HOLD_CYCLES) ?
                          ((RELEASE_MAX > REAPPLY_CYCLES) ? RELEASE_MAX : REAPPLY_CYCLES) :
                          ((HOLD_CYCLES > REAPPLY_CYCLES) ? HOLD_CYCLES : REAPPLY_CYCLES);
    localparam int TW   = $clog2(TMAX + 1);
    localparam int CW   = $clog2(MAX_ABS_CYCLES + 1);

    logic [SPEED_W-1:0] w_diff;
    logic [6:0]         w_enter_pct;
    logic [PW-1:0]      w_slip100;
    logic [PW-1:0]      w_enter_lim;
    logic [PW-1:0]      w_exit_lim;
    logic               w_below;
    logic               w_enter;
    logic               w_exit;

    logic               r_enter;
    logic               r_exit;
    abs_state_t         r_state;
    ch_out_t            r_out;
    logic [TW-1:0]      r_timer;
    logic [CW-1:0]      r_cyc_cnt;

    // slip% > P  <=>  (v - w) * 100 > P * v, evaluated only when w < v
    assign w_enter_pct = i_inner ? 7'(SLIP_ENTER_PCT + STEER_COMP_PCT) : 7'(SLIP_ENTER_PCT);
    assign w_diff      = i_vehicle - i_wheel;
    assign w_slip100   = PW'(w_diff) * PW'(100);
    assign w_enter_lim = PW'(i_vehicle) * PW'(w_enter_pct);
    assign w_exit_lim  = PW'(i_vehicle) * PW'(SLIP_EXIT_PCT);
    assign w_below     = (i_wheel < i_vehicle);
    assign w_enter     = w_below && (w_slip100 > w_enter_lim);
    assign w_exit      = !w_below || (w_slip100 < w_exit_lim);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_enter   <= 1'b0;
            r_exit    <= 1'b0;
            r_state   <= ST_NORMAL;
            r_out     <= st_outs(ST_NORMAL);
            r_timer   <= '0;
            r_cyc_cnt <= '0;
        end else begin
            r_enter <= w_enter;
            r_exit  <= w_exit;
            if (!i_brake)
                r_cyc_cnt <= '0;
            // disarm and fault beat any timer expiry on the same edge
            if (!i_armed || i_fault) begin
                r_state <= ST_NORMAL;
                r_out   <= st_outs(ST_NORMAL);
            end else begin
                case (r_state)
                    ST_NORMAL: begin
                        if (r_enter) begin
                            r_state <= ST_HOLD;
                            r_out   <= st_outs(ST_HOLD);
                            r_timer <= TW'(HOLD_CYCLES - 1);
                        end
                    end
                    ST_HOLD: begin
                        if (r_timer == '0) begin
                            r_state <= ST_RELEASE;
                            r_out   <= st_outs(ST_RELEASE);
                            r_timer <= TW'(RELEASE_MAX - 1);
                        end else begin
                            r_timer <= r_timer - TW'(1);
                        end
                    end
                    ST_RELEASE: begin
                        if (r_exit || r_timer == '0) begin
                            r_state <= ST_REAPPLY;
                            r_out   <= st_outs(ST_REAPPLY);
                            r_timer <= TW'(REAPPLY_CYCLES - 1);
                        end else begin
                            r_timer <= r_timer - TW'(1);
                        end
                    end
                    ST_REAPPLY: begin
                        if (r_timer == '0) begin
                            if (r_cyc_cnt != CW'(MAX_ABS_CYCLES))
                                r_cyc_cnt <= r_cyc_cnt + CW'(1);
                            r_state <= r_enter ? ST_HOLD : ST_NORMAL;
                            r_out   <= st_outs(r_enter ? ST_HOLD : ST_NORMAL);
                            r_timer <= TW'(HOLD_CYCLES - 1);
                        end else begin
                            r_timer <= r_timer - TW'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_NORMAL;
                        r_out   <= st_outs(ST_NORMAL);
                    end
                endcase
            end
        end
    end

    assign o_vrc1    = r_out.vrc1;
    assign o_vrc2    = r_out.vrc2;
    assign o_active  = r_out.active;
    assign o_cyc_max = (r_cyc_cnt == CW'(MAX_ABS_CYCLES));

endmodule

// File: rtl/abs_multichannel_ctrl.sv
// N-wheel ABS controller top: arming register, sticky fault, recovery pump OR.
// Optional feature macro ABS_STEER_COMP_EN raises the enter threshold of inner wheels.
module abs_multichannel_ctrl
    import abs_pkg::*;
#(
    parameter int N_WHEELS       = 4,
    parameter int SPEED_W        = 8,
    parameter int SLIP_ENTER_PCT = 20,
    parameter int SLIP_EXIT_PCT  = 10,
    parameter int MIN_SPEED      = 5,
    parameter int HOLD_CYCLES    = 4,
    parameter int RELEASE_MAX    = 32,
    parameter int REAPPLY_CYCLES = 8,
    parameter int MAX_ABS_CYCLES = 8,
    parameter int STEER_COMP_PCT = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_WHEELS*SPEED_W-1:0] wheel_speed,
    input  logic [SPEED_W-1:0]          vehicle_speed,
    input  logic [1:0]                  direction,
    input  logic                        brake_signal,
    input  logic                        engine_status,
    output logic [N_WHEELS-1:0]         Vrc1,
    output logic [N_WHEELS-1:0]         Vrc2,
    output logic                        recovery_pump,
    output logic [N_WHEELS-1:0]         abs_active,
    output logic                        fault
);

    logic                r_armed;
    logic                r_brake;
    logic                r_fault;
    logic [N_WHEELS-1:0] w_inner;
    logic [N_WHEELS-1:0] w_cyc_max;

    // armed and brake share the pipeline stage of the per-channel slip flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_armed <= 1'b0;
            r_brake <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_armed <= brake_signal && engine_status && (vehicle_speed > SPEED_W'(MIN_SPEED));
            r_brake <= brake_signal;
            r_fault <= r_fault | (|w_cyc_max);
        end
    end

`ifndef ABS_STEER_COMP_EN
    logic [1:0] w_unused_dir;
    assign w_unused_dir = direction;
`endif

    for (genvar g = 0; g < N_WHEELS; g++) begin : g_ch
`ifdef ABS_STEER_COMP_EN
        assign w_inner[g] = (g % 2 == 0) ? (direction == DIR_LEFT) : (direction == DIR_RIGHT);
`else
        assign w_inner[g] = 1'b0;
`endif
        abs_wheel_channel #(
            .SPEED_W        (SPEED_W),
            .SLIP_ENTER_PCT (SLIP_ENTER_PCT),
            .SLIP_EXIT_PCT  (SLIP_EXIT_PCT),
            .STEER_COMP_PCT (STEER_COMP_PCT),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .RELEASE_MAX    (RELEASE_MAX),
            .REAPPLY_CYCLES (REAPPLY_CYCLES),
            .MAX_ABS_CYCLES (MAX_ABS_CYCLES)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .i_wheel   (wheel_speed[g*SPEED_W +: SPEED_W]),
            .i_vehicle (vehicle_speed),
            .i_inner   (w_inner[g]),
            .i_armed   (r_armed),
            .i_brake   (r_brake),
            .i_fault   (r_fault),
            .o_vrc1    (Vrc1[g]),
            .o_vrc2    (Vrc2[g]),
            .o_active  (abs_active[g]),
            .o_cyc_max (w_cyc_max[g])
        );
    end

    assign recovery_pump = |Vrc2;
    assign fault         = r_fault;

endmodule

// File: tb/tb_abs_multichannel_ctrl.sv
// Directed and randomized bench for abs_multichannel_ctrl against a cycle-level
// behavioural model of the wheel phases, slip rules and fault latch.
module tb_abs_multichannel_ctrl;

    localparam int N      = 4;
    localparam int SW     = 8;
    localparam int ENTER  = 20;
    localparam int EXIT   = 10;
    localparam int MINS   = 5;
    localparam int HOLD   = 4;
    localparam int RELMAX = 32;
    localparam int REAP   = 8;
    localparam int MAXC   = 8;
    localparam int STEER  = 5;

    localparam int P_NORM = 0;
    localparam int P_HOLD = 1;
    localparam int P_REL  = 2;
    localparam int P_REAP = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [SW-1:0] w [N];
    logic [N*SW-1:0] wheel_speed;
    logic [SW-1:0] vehicle_speed;
    logic [1:0]    direction;
    logic          brake_signal;
    logic          engine_status;
    logic [N-1:0]  Vrc1;
    logic [N-1:0]  Vrc2;
    logic          recovery_pump;
    logic [N-1:0]  abs_active;
    logic          fault;

    int m_ph  [N];
    int m_el  [N];
    int m_cnt [N];
    bit f_en  [N];
    bit f_ex  [N];
    bit f_armed, f_brake, m_fault;
    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign wheel_speed[g*SW +: SW] = w[g];
    end

    abs_multichannel_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .wheel_speed   (wheel_speed),
        .vehicle_speed (vehicle_speed),
        .direction     (direction),
        .brake_signal  (brake_signal),
        .engine_status (engine_status),
        .Vrc1          (Vrc1),
        .Vrc2          (Vrc2),
        .recovery_pump (recovery_pump),
        .abs_active    (abs_active),
        .fault         (fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // one clock edge of the reference: phases advance on last edge's flags,
    // then flags are re-evaluated from the inputs present at this edge
    task automatic model_edge();
        bit nf;
        int vv, ww, thr;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_ph[i] = P_NORM; m_el[i] = 0; m_cnt[i] = 0; f_en[i] = 0; f_ex[i] = 0;
            end
            f_armed = 0; f_brake = 0; m_fault = 0;
            return;
        end
        nf = m_fault;
        for (int i = 0; i < N; i++) if (m_cnt[i] >= MAXC) nf = 1;
        for (int i = 0; i < N; i++) begin
            if (!f_brake) m_cnt[i] = 0;
            if (!f_armed || m_fault) begin
                m_ph[i] = P_NORM; m_el[i] = 0;
            end else if (m_ph[i] == P_NORM) begin
                if (f_en[i]) begin m_ph[i] = P_HOLD; m_el[i] = 0; end
            end else if (m_ph[i] == P_HOLD) begin
                m_el[i]++;
                if (m_el[i] == HOLD) begin m_ph[i] = P_REL; m_el[i] = 0; end
            end else if (m_ph[i] == P_REL) begin
                m_el[i]++;
                if (f_ex[i] || m_el[i] == RELMAX) begin m_ph[i] = P_REAP; m_el[i] = 0; end
            end else begin
                m_el[i]++;
                if (m_el[i] == REAP) begin
                    if (m_cnt[i] < MAXC) m_cnt[i]++;
                    m_ph[i] = f_en[i] ? P_HOLD : P_NORM;
                    m_el[i] = 0;
                end
            end
        end
        vv = int'(vehicle_speed);
        f_armed = brake_signal && engine_status && (vv > MINS);
        f_brake = brake_signal;
        for (int i = 0; i < N; i++) begin
            ww  = int'(w[i]);
            thr = ENTER;
`ifdef ABS_STEER_COMP_EN
            if ((direction == 2'b01 && i % 2 == 0) || (direction == 2'b10 && i % 2 == 1))
                thr = ENTER + STEER;
`endif
            f_en[i] = (ww < vv) && ((vv - ww) * 100 > thr * vv);
            f_ex[i] = (ww >= vv) || ((vv - ww) * 100 < EXIT * vv);
        end
        m_fault = nf;
    endtask

    task automatic check_all();
        logic [N-1:0] e1, e2, ea;
        for (int i = 0; i < N; i++) begin
            e1[i] = (m_ph[i] == P_NORM) || (m_ph[i] == P_REAP);
            e2[i] = (m_ph[i] == P_REL);
            ea[i] = (m_ph[i] != P_NORM);
        end
        chk("model_vrc1",   32'(Vrc1),          32'(e1));
        chk("model_vrc2",   32'(Vrc2),          32'(e2));
        chk("model_active", 32'(abs_active),    32'(ea));
        chk("model_pump",   32'(recovery_pump), 32'(|e2));
        chk("model_fault",  32'(fault),         32'(m_fault));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            cyc++;
            check_all();
        end
    endtask

    task automatic set_all(input int spd);
        for (int i = 0; i < N; i++) w[i] = SW'(spd);
    endtask

    initial begin
        int vr, wr;
        reset = 1'b1; brake_signal = 1'b0; engine_status = 1'b0;
        vehicle_speed = '0; direction = 2'b00; set_all(0);
        step(2);
        chk("rst_vrc1", 32'(Vrc1), 32'hF);
        chk("rst_vrc2", 32'(Vrc2), 32'h0);
        chk("rst_active", 32'(abs_active), 32'h0);
        chk("rst_fault", 32'(fault), 32'h0);
        reset = 1'b0;

        // equal speeds: nothing engages
        vehicle_speed = 8'd100; set_all(100); brake_signal = 1'b1; engine_status = 1'b1;
        step(5);
        chk("t1_vrc1", 32'(Vrc1), 32'hF);
        chk("t1_vrc2", 32'(Vrc2), 32'h0);

        // full cycle on ch0
        w[0] = 8'd70;
        step(2);
        chk("t2_hold_vrc1", 32'(Vrc1[0]), 32'h0);
        step(4);
        chk("t2_rel_vrc2", 32'(Vrc2[0]), 32'h1);
        chk("t2_rel_pump", 32'(recovery_pump), 32'h1);
        w[0] = 8'd95;
        step(2);
        chk("t2_reap_vrc1", 32'(Vrc1[0]), 32'h1);
        chk("t2_reap_active", 32'(abs_active[0]), 32'h1);
        step(8);
        chk("t2_normal", 32'(abs_active[0]), 32'h0);

        // exactly 20% slip does not engage, 21% does
        w[1] = 8'd80;
        step(4);
        chk("t3_eq20", 32'(abs_active[1]), 32'h0);
        w[1] = 8'd79;
        step(2);
        chk("t3_gt20", 32'(abs_active[1]), 32'h1);
        w[1] = 8'd100;
        step(20);

        // brake drop in RELEASE, then reset in HOLD
        w[0] = 8'd70;
        step(6);
        chk("t5_rel", 32'(Vrc2[0]), 32'h1);
        brake_signal = 1'b0;
        step(2);
        chk("t5_drop", 32'(abs_active), 32'h0);
        brake_signal = 1'b1;
        step(2);
        chk("t5_hold", 32'(Vrc1[0]), 32'h0);
        reset = 1'b1;
        step(1);
        chk("t5_rst_vrc1", 32'(Vrc1), 32'hF);
        chk("t5_rst_active", 32'(abs_active), 32'h0);
        reset = 1'b0; w[0] = 8'd100;
        step(3);

        // persistent lock on ch2 until the cycle limit trips the fault
        w[2] = 8'd50;
        step(400);
        chk("t4_fault", 32'(fault), 32'h1);
        chk("t4_vrc1", 32'(Vrc1), 32'hF);
        chk("t4_vrc2", 32'(Vrc2), 32'h0);
        chk("t4_pump", 32'(recovery_pump), 32'h0);
        w[2] = 8'd100; brake_signal = 1'b0;
        step(10);
        chk("t4_sticky", 32'(fault), 32'h1);

        // steering compensation on a left turn
        reset = 1'b1;
        step(1);
        reset = 1'b0; brake_signal = 1'b1; set_all(100);
        direction = 2'b01; w[0] = 8'd77; w[1] = 8'd77;
        step(3);
`ifdef ABS_STEER_COMP_EN
        chk("t6_steer", 32'(abs_active[1:0]), 32'h2);
`else
        chk("t6_steer", 32'(abs_active[1:0]), 32'h3);
`endif

        // randomized segments against the model
        for (int s = 0; s < 150; s++) begin
            vr = $urandom_range(0, 255);
            vehicle_speed = SW'(vr);
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 4))
                    0: wr = vr;
                    1: wr = vr - (vr * $urandom_range(0, 12)) / 100;
                    2: wr = vr - (vr * $urandom_range(15, 60)) / 100;
                    3: wr = (vr + $urandom_range(0, 30) > 255) ? 255 : vr + $urandom_range(0, 30);
                    default: wr = $urandom_range(0, 255);
                endcase
                w[i] = SW'(wr);
            end
            brake_signal  = ($urandom_range(0, 9) != 0);
            engine_status = ($urandom_range(0, 19) != 0);
            direction     = 2'($urandom_range(0, 3));
            reset         = ($urandom_range(0, 39) == 0);
            step(1);
            reset = 1'b0;
            step($urandom_range(1, 40));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
